clkrstgen: RTL and testbench
============================

# clkrstgen

Parametrised clock and reset generator for FPGA board tops, replacing the fixed divide-by-4 clock generator and raw button reset. It divides the oscillator clock `CLK` by any even ratio to produce the system clock `clk`. It also derives the active-high `power_on_reset` for `system`, with three properties: asynchronous assertion, synchronised and debounced button release, and a stretch of a programmable number of `clk` cycles. Optionally, a `trap` from `system` restarts the reset sequence.

## Interface
- `DIV`, default 4: `CLK`→`clk` division ratio. Must be even and ≥2; any other value is an elaboration error.
- `DEBOUNCE`, default 1024: number of `CLK` cycles the synchronised button must stay released before stretching starts. Must be ≥1.
- `RSTCYCLES`, default 16: number of `clk` falling edges `power_on_reset` is held after debounce. Must be ≥1.
- `CLK`  in  1  oscillator clock; the only clock in the block.
- `BTN_N`  in  1  reset. Asynchronous, active-low.
- `trap`  in  1  trap flag from `system`, in the `clk` domain.
- `clk`  out  1  divided system clock, registered.
- `power_on_reset`  out  1  active-high reset to `system`, registered.

## Operation
- Divider:
  - counter `cnt`, width `$clog2(DIV/2)` (minimum 1), counts `CLK` edges.
  - When `cnt == DIV/2-1`: `clk` toggles and `cnt` returns to 0. Otherwise `cnt` increments.
  - Gives a 50 % duty cycle.
- Synchroniser: a 2-flop chain `s1`/`s2`, shifting in 1.
- State machine (all transitions on `CLK` rising edge):
  - `RESET`: go to `DEBOUNCE` when `s2 == 1`.
  - `DEBOUNCE`: `dcnt` increments each cycle. When `dcnt == DEBOUNCE-1`, go to `STRETCH` and clear `dcnt`.
  - `STRETCH`: `rcnt` increments on each `CLK` edge where `clk` toggles 1→0. On the edge completing the `RSTCYCLES`-th fall, go to `RUN` and clear `rcnt`.
  - `RUN`: stays in `RUN`, except for the trap restart under Configuration.
- `power_on_reset` = 1 in every state except `RUN`. It is registered, so it falls on the same `CLK` edge that enters `RUN`, which coincides with a `clk` falling edge. This gives `system` half a `clk` period of setup before its next rising edge.
- `BTN_N` low at any time, including mid-`DEBOUNCE` or mid-`STRETCH`, asynchronously forces:
  - `clk` = 0, `cnt` = 0
  - `s1` = `s2` = 0
  - `dcnt` = `rcnt` = 0
  - state `RESET`, `power_on_reset` = 1
- Button bounce therefore restarts the whole sequence. No partial count survives a bounce.
- The divider is held in reset while `BTN_N` is low and runs freely otherwise, in every state.

## Timing
- Reset values: `clk` = 0, `power_on_reset` = 1.
- `power_on_reset` rises asynchronously as soon as `BTN_N` goes low.
- Edge numbering: edge 1 is the first `CLK` rising edge with `BTN_N` high.
  - `clk` rises at edge `DIV/2`.
  - `clk` falls at edges `k·DIV`.
  - `s2` = 1 after edge 2.
  - `DEBOUNCE` is entered at edge 3.
  - `STRETCH` is entered at edge `2+DEBOUNCE`.
- Deassertion latency: `power_on_reset` falls at the `RSTCYCLES`-th `clk` falling edge strictly after entering `STRETCH`.
- A `clk` fall on the same edge that enters `STRETCH` is not counted.
- `clk` has no glitches and no truncated pulses, except the asynchronous force-to-0 on `BTN_N` assertion.

## Configuration
- `CLKRSTGEN_TRAP_RESET_EN`
  - Defined: in `RUN`, `trap` is sampled on each `CLK` edge where `clk` falls.
    - If 1: go to `STRETCH` with `rcnt` = 0, and `power_on_reset` = 1 from that edge.
    - Release then follows the normal `STRETCH` rule. Debounce is skipped.
  - Not defined: `trap` is ignored, and `RUN` is left only via `BTN_N`.
  - The `trap` port is present in both builds.

## Test plan
- Divider with `DIV` = 4, `DIV` = 2, `DIV` = 10, `BTN_N` held high:
  - `clk` period is 4, 2 and 10 `CLK` cycles respectively.
  - `clk` high for exactly `DIV/2` cycles; first rise at edge `DIV/2`.
- Nominal release, `DIV` = 4, `DEBOUNCE` = 8, `RSTCYCLES` = 2: release `BTN_N` → `power_on_reset` falls at `CLK` edge 16, coincident with a `clk` fall. It stays 0 for 1000 cycles.
- Bounce, same parameters: release `BTN_N`, pulse it low for 1 cycle at edge 7, then release for good. `power_on_reset` stays 1 throughout and falls at edge 16 counted from the final release.
- Mid-stretch reset, same parameters: assert `BTN_N` low at edge 13 → `power_on_reset` = 1 and `clk` = 0 immediately, without waiting for a `CLK` edge. The sequence restarts from the next release.
- Trap, with `CLKRSTGEN_TRAP_RESET_EN`, in `RUN`, `DIV` = 4, `RSTCYCLES` = 2: drive `trap` = 1 for one `clk` cycle.
  - `power_on_reset` rises at the next `clk` fall and falls exactly 8 `CLK` cycles later.
  - Without the macro, `power_on_reset` stays 0.

Source files
------------

// File: rtl/clkrstgen.sv
// clkrstgen: clock and reset generator for FPGA board tops.
//
// Divides the oscillator clock CLK by an even ratio DIV into the system clock clk
// (50 % duty). Produces power_on_reset for the system: asserted asynchronously by
// BTN_N low, released only after BTN_N has been synchronised, stayed high for
// DEBOUNCE CLK cycles, and RSTCYCLES further falling edges of clk have passed.
//
// Ports:
//   CLK            in   oscillator clock (only clock in the block)
//   BTN_N          in   asynchronous active-low reset button
//   trap           in   trap flag from the system, clk domain
//   clk            out  divided system clock, registered
//   power_on_reset out  active-high system reset, registered
//
// Optional feature macro: CLKRSTGEN_TRAP_RESET_EN
//   Defined:   a trap seen on a clk falling edge while running restarts the stretch.
//   Undefined: trap is ignored.
module clkrstgen #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned DEBOUNCE  = 1024,
  parameter int unsigned RSTCYCLES = 16
) (
  input  logic CLK,
  input  logic BTN_N,
  input  logic trap,
  output logic clk,
  output logic power_on_reset
);

  localparam int unsigned Half = DIV / 2;
  localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;
  localparam int unsigned DW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned RW   = (RSTCYCLES > 1) ? $clog2(RSTCYCLES) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(Half - 1);
  localparam logic [DW-1:0]   DLast   = DW'(DEBOUNCE - 1);
  localparam logic [RW-1:0]   RLast   = RW'(RSTCYCLES - 1);

  if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
    $error("clkrstgen: DIV must be even and >= 2");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("clkrstgen: DEBOUNCE must be >= 1");
  end
  if (RSTCYCLES < 1) begin : g_bad_rstcycles
    $error("clkrstgen: RSTCYCLES must be >= 1");
  end

  // Divider
  logic [CntW-1:0] cnt_q;
  logic            clk_q;
  logic            toggle;
  logic            fall;

  assign toggle = (cnt_q == CntLast);
  assign fall   = toggle & clk_q;  // this CLK edge takes clk from 1 to 0

  always_ff @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else if (toggle) begin
      cnt_q <= '0;
      clk_q <= ~clk_q;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Button release synchroniser
  logic s1_q, s2_q;

  always_ff @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= 1'b1;
      s2_q <= s1_q;
    end
  end

  // Reset sequencer
  typedef enum logic [1:0] {StReset, StDebounce, StStretch, StRun} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          por_q, por_d;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      // The edge that first sees s2 high already counts as debounce cycle one, so
      // stretching begins DEBOUNCE cycles after s2 rises.
      StReset: begin
        if (s2_q) begin
          if (dcnt_q == DLast) begin
            state_d = StStretch;
          end else begin
            state_d = StDebounce;
            dcnt_d  = dcnt_q + DW'(1);
          end
        end
      end
      StDebounce: begin
        if (dcnt_q == DLast) begin
          state_d = StStretch;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      StStretch: begin
        if (fall) begin
          if (rcnt_q == RLast) begin
            state_d = StRun;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end
      StRun: begin
`ifdef CLKRSTGEN_TRAP_RESET_EN
        if (fall && trap) begin
          state_d = StStretch;
          rcnt_d  = '0;
        end
`endif
      end
      default: state_d = StReset;
    endcase
    // Registered from the next state so release lands exactly on a clk fall.
    por_d = (state_d != StRun);
  end

`ifndef CLKRSTGEN_TRAP_RESET_EN
  logic unused_trap;
  assign unused_trap = trap;
`endif

  always_ff @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) begin
      state_q <= StReset;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      por_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      por_q   <= por_d;
    end
  end

  assign clk            = clk_q;
  assign power_on_reset = por_q;

endmodule

// File: tb/tb_clkrstgen.sv
// Testbench for clkrstgen: three instances (DIV = 4, 2, 10) sharing CLK and BTN_N,
// checked every cycle against an edge-count model plus directed literal checks.
module tb_clkrstgen;

  localparam int Db = 8;
  localparam int Rc = 2;
`ifdef CLKRSTGEN_TRAP_RESET_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic BTN_N = 1'b1;
  logic trap  = 1'b0;
  logic no_trap = 1'b0;
  logic clk4, por4, clk2, por2, clk10, por10;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int n = 0;           // CLK rising edges since the last release of BTN_N
  int trap_until = 0;  // main instance held in reset until this edge after a trap

  always #5 CLK = ~CLK;

  clkrstgen #(.DIV(4), .DEBOUNCE(Db), .RSTCYCLES(Rc)) u_d4 (
    .CLK(CLK), .BTN_N(BTN_N), .trap(trap), .clk(clk4), .power_on_reset(por4)
  );
  clkrstgen #(.DIV(2), .DEBOUNCE(Db), .RSTCYCLES(Rc)) u_d2 (
    .CLK(CLK), .BTN_N(BTN_N), .trap(no_trap), .clk(clk2), .power_on_reset(por2)
  );
  clkrstgen #(.DIV(10), .DEBOUNCE(Db), .RSTCYCLES(Rc)) u_d10 (
    .CLK(CLK), .BTN_N(BTN_N), .trap(no_trap), .clk(clk10), .power_on_reset(por10)
  );

  // Stretch starts at edge 2+Db; release is the Rc-th multiple of div after it.
  function automatic int rel_edge(int div);
    return ((2 + Db) / div + Rc) * div;
  endfunction

  function automatic logic exp_clk(int e, int div);
    return ((e / (div / 2)) % 2) == 1;
  endfunction

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_edges(int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  // Model state
  always @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) begin
      n          <= 0;
      trap_until <= 0;
    end else begin
      n <= n + 1;
      if (TrapEn && trap && n >= rel_edge(4) && n >= trap_until && (n + 1) % 4 == 0)
        trap_until <= n + 1 + Rc * 4;
    end
  end

  // Per-cycle comparison
  always @(negedge CLK) begin
    if (chk_en) begin
      check("clk_div4", clk4, exp_clk(n, 4));
      check("clk_div2", clk2, exp_clk(n, 2));
      check("clk_div10", clk10, exp_clk(n, 10));
      check("por_div4", por4, !(n >= rel_edge(4) && n >= trap_until));
      check("por_div2", por2, !(n >= rel_edge(2)));
      check("por_div10", por10, !(n >= rel_edge(10)));
    end
  end

  initial begin
    #1 BTN_N = 1'b0;
    #1 chk_en = 1'b1;
    wait_edges(3);
    check("reset_clk", clk4, 1'b0);
    check("reset_por", por4, 1'b1);

    // Nominal release
    #1 BTN_N = 1'b1;
    wait_edges(1);
    check("div2_first_rise_e1", clk2, 1'b1);
    check("div4_low_e1", clk4, 1'b0);
    wait_edges(1);
    check("div4_first_rise_e2", clk4, 1'b1);
    wait_edges(2);
    check("div10_low_e4", clk10, 1'b0);
    wait_edges(1);
    check("div10_first_rise_e5", clk10, 1'b1);
    wait_edges(10);
    check("nominal_por_e15", por4, 1'b1);
    wait_edges(1);
    check("nominal_por_e16", por4, 1'b0);
    check("nominal_clk_e16", clk4, 1'b0);
    wait_edges(1000);
    check("nominal_por_hold", por4, 1'b0);

    // Bounce: low pulse across edge 7, then final release
    #1 BTN_N = 1'b0;
    #1 check("bounce_async_por", por4, 1'b1);
    wait_edges(2);
    #1 BTN_N = 1'b1;
    wait_edges(6);
    #1 BTN_N = 1'b0;
    @(posedge CLK);
    #2 BTN_N = 1'b1;
    wait_edges(15);
    check("bounce_por_e15", por4, 1'b1);
    wait_edges(1);
    check("bounce_por_e16", por4, 1'b0);

    // Mid-stretch reset at edge 13
    #1 BTN_N = 1'b0;
    wait_edges(2);
    #1 BTN_N = 1'b1;
    wait_edges(13);
    check("midstretch_clk2_e13", clk2, 1'b1);
    #1 BTN_N = 1'b0;
    #1;
    check("midstretch_async_por", por4, 1'b1);
    check("midstretch_async_clk2", clk2, 1'b0);
    check("midstretch_async_clk4", clk4, 1'b0);
    wait_edges(1);
    #1 BTN_N = 1'b1;
    wait_edges(15);
    check("restart_por_e15", por4, 1'b1);
    wait_edges(1);
    check("restart_por_e16", por4, 1'b0);

    // Trap for one clk cycle starting at the clk rise on edge 22
    wait_edges(6);
    #1 trap = 1'b1;
    wait_edges(1);
    check("trap_por_e23", por4, 1'b0);
    wait_edges(1);
    check("trap_por_e24", por4, TrapEn);
    wait_edges(2);
    #1 trap = 1'b0;
    wait_edges(5);
    check("trap_por_e31", por4, TrapEn);
    wait_edges(1);
    check("trap_por_e32", por4, 1'b0);
    wait_edges(20);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
